// File: rtl/ram_hex_display_if.sv
// Bundle of the switch/RAM/HEX signals around the RAM-lab display front-end.
// Hex buses are packed per digit: [digit][segment], digit 0 = least significant nibble.
interface ram_hex_display_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  localparam int ADDR_DIG = (ADDR_W + 3) / 4;
  localparam int DATA_DIG = (DATA_W + 3) / 4;

  logic                         scan_en;
  logic [ADDR_W-1:0]            man_addr;
  logic [DATA_W-1:0]            wr_data;
  logic [DATA_W-1:0]            rd_data;
  logic [ADDR_W-1:0]            rd_addr;
  logic                         step;
  logic [ADDR_DIG-1:0][6:0]     hex_addr;
  logic [DATA_DIG-1:0][6:0]     hex_wdata;
  logic [DATA_DIG-1:0][6:0]     hex_rdata;

  modport master (
    output scan_en, man_addr, wr_data, rd_data,
    input  rd_addr, step, hex_addr, hex_wdata, hex_rdata
  );

  modport slave (
    input  scan_en, man_addr, wr_data, rd_data,
    output rd_addr, step, hex_addr, hex_wdata, hex_rdata
  );
endinterface

// File: rtl/ram_hex_display.sv
// RAM-lab display front-end: manual/scan read-address source plus active-low 7-segment encoders.
// Optional macro HEX_ZERO_BLANK_EN blanks leading-zero address digits (digit 0 always shown).
module ram_hex_display #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input logic              clk,
  input logic              reset_n,
  ram_hex_display_if.slave bus
);
  localparam int ADDR_DIG = (ADDR_W + 3) / 4;
  localparam int DATA_DIG = (DATA_W + 3) / 4;
  localparam int ADDR_PAD = ADDR_DIG * 4;
  localparam int DATA_PAD = DATA_DIG * 4;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]         cnt_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic                     step;
  logic [ADDR_PAD-1:0]      addr_pad;
  logic [DATA_PAD-1:0]      wdata_pad;
  logic [DATA_PAD-1:0]      rdata_pad;
  logic [ADDR_DIG-1:0][6:0] addr_seg;
  logic [DATA_DIG-1:0][6:0] wdata_seg;
  logic [DATA_DIG-1:0][6:0] rdata_seg;
  logic [ADDR_DIG-1:0][6:0] hex_addr_q;
  logic [DATA_DIG-1:0][6:0] hex_wdata_q;
  logic [DATA_DIG-1:0][6:0] hex_rdata_q;

  // step is gated by the live scan_en so a same-cycle drop to manual suppresses the increment
  assign step = bus.scan_en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!bus.scan_en || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
    end else if (!bus.scan_en) begin
      rd_addr_q <= bus.man_addr;
    end else if (step) begin
      rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    addr_pad  = '0;
    wdata_pad = '0;
    rdata_pad = '0;
    addr_pad[ADDR_W-1:0]  = rd_addr_q;
    wdata_pad[DATA_W-1:0] = bus.wr_data;
    rdata_pad[DATA_W-1:0] = bus.rd_data;
  end

`ifdef HEX_ZERO_BLANK_EN
  logic lead_zero;

  always_comb begin
    addr_seg  = '0;
    lead_zero = 1'b1;
    for (int i = ADDR_DIG - 1; i >= 0; i--) begin
      if (addr_pad[i*4 +: 4] != 4'h0) lead_zero = 1'b0;
      if (lead_zero && i != 0) addr_seg[i] = SEG_BLANK;
      else                     addr_seg[i] = seg7(addr_pad[i*4 +: 4]);
    end
  end
`else
  always_comb begin
    addr_seg = '0;
    for (int i = 0; i < ADDR_DIG; i++) begin
      addr_seg[i] = seg7(addr_pad[i*4 +: 4]);
    end
  end
`endif

  always_comb begin
    wdata_seg = '0;
    rdata_seg = '0;
    for (int i = 0; i < DATA_DIG; i++) begin
      wdata_seg[i] = seg7(wdata_pad[i*4 +: 4]);
      rdata_seg[i] = seg7(rdata_pad[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_addr_q  <= {ADDR_DIG{SEG_BLANK}};
      hex_wdata_q <= {DATA_DIG{SEG_BLANK}};
      hex_rdata_q <= {DATA_DIG{SEG_BLANK}};
    end else begin
      hex_addr_q  <= addr_seg;
      hex_wdata_q <= wdata_seg;
      hex_rdata_q <= rdata_seg;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.step      = step;
  assign bus.hex_addr  = hex_addr_q;
  assign bus.hex_wdata = hex_wdata_q;
  assign bus.hex_rdata = hex_rdata_q;
endmodule

// File: tb/tb_ram_hex_display.sv
// Scoreboard bench for ram_hex_display (ADDR_W=5, DATA_W=4, TICK_DIV=4).
// Stimulus schedules expectations by cycle; a negedge monitor compares and retires them.
module tb_ram_hex_display;
  localparam logic [6:0] SEG_0  = 7'b1000000;
  localparam logic [6:0] SEG_1  = 7'b1111001;
  localparam logic [6:0] SEG_5  = 7'b0010010;
  localparam logic [6:0] SEG_A  = 7'b0001000;
  localparam logic [6:0] SEG_F  = 7'b0001110;
  localparam logic [6:0] BLANK  = 7'b1111111;
`ifdef HEX_ZERO_BLANK_EN
  localparam logic [6:0] LEAD0  = BLANK;
`else
  localparam logic [6:0] LEAD0  = SEG_0;
`endif

  localparam int K_RD = 0, K_STEP = 1, K_HA0 = 2, K_HA1 = 3, K_HW = 4, K_HR = 5;

  typedef struct {
    int         due;
    int         kind;
    logic [6:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t keep_q[$];

  ram_hex_display_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  ram_hex_display #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] actual(input int kind);
    case (kind)
      K_RD:    return {2'b00, bus.rd_addr};
      K_STEP:  return {6'b0, bus.step};
      K_HA0:   return bus.hex_addr[0];
      K_HA1:   return bus.hex_addr[1];
      K_HW:    return bus.hex_wdata[0];
      default: return bus.hex_rdata[0];
    endcase
  endfunction

  task automatic expect_at(input int due, input int kind, input logic [6:0] val, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: retire every expectation due this cycle; anything overdue is a failure
  always @(negedge clk) begin
    logic [6:0] a;
    keep_q = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        n_run++;
        a = actual(exp_q[i].kind);
        if (a !== exp_q[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %b, expected %b", exp_q[i].name, cyc, a, exp_q[i].val);
        end
      end else if (exp_q[i].due < cyc) begin
        n_run++;
        n_fail++;
        $display("FAIL %s: expectation for cyc %0d never checked", exp_q[i].name, exp_q[i].due);
      end else begin
        keep_q.push_back(exp_q[i]);
      end
    end
    exp_q = keep_q;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t, r;
    reset_n      = 1'b1;
    bus.scan_en  = 1'b0;
    bus.man_addr = '0;
    bus.wr_data  = '0;
    bus.rd_data  = '0;
    #2 reset_n = 1'b0;
    tick(2);

    // reset state
    expect_at(cyc, K_RD,   7'h00, "reset_rd_addr");
    expect_at(cyc, K_STEP, 7'h00, "reset_step");
    expect_at(cyc, K_HA0,  BLANK, "reset_hex_addr0");
    expect_at(cyc, K_HA1,  BLANK, "reset_hex_addr1");
    expect_at(cyc, K_HW,   BLANK, "reset_hex_wdata");
    expect_at(cyc, K_HR,   BLANK, "reset_hex_rdata");

    // manual mode and data path
    reset_n      = 1'b1;
    bus.man_addr = 5'h1A;
    bus.wr_data  = 4'hF;
    bus.rd_data  = 4'h5;
    expect_at(cyc + 1, K_RD,  7'h1A, "man_rd_addr_1A");
    expect_at(cyc + 1, K_HW,  SEG_F, "wdata_F");
    expect_at(cyc + 1, K_HR,  SEG_5, "rdata_5");
    expect_at(cyc + 1, K_HA0, SEG_0, "hex_addr0_prev_0");
    expect_at(cyc + 2, K_HA0, SEG_A, "hex_addr0_A");
    expect_at(cyc + 2, K_HA1, SEG_1, "hex_addr1_1");
    tick(2);

    // scan from 1F with wrap
    bus.man_addr = 5'h1F;
    tick(1);
    s = cyc;
    bus.scan_en = 1'b1;
    expect_at(s,     K_RD,   7'h1F, "scan_start_1F");
    expect_at(s,     K_STEP, 7'h00, "step_low_s0");
    expect_at(s + 1, K_HA0,  SEG_F, "hex_addr0_F");
    expect_at(s + 1, K_HA1,  SEG_1, "hex_addr1_1_of_1F");
    expect_at(s + 1, K_STEP, 7'h00, "step_low_s1");
    expect_at(s + 2, K_STEP, 7'h00, "step_low_s2");
    expect_at(s + 3, K_STEP, 7'h01, "step_first");
    expect_at(s + 3, K_RD,   7'h1F, "rd_addr_in_step");
    expect_at(s + 4, K_STEP, 7'h00, "step_one_cycle");
    expect_at(s + 4, K_RD,   7'h00, "wrap_to_00");
    expect_at(s + 5, K_HA0,  SEG_0, "hex_addr0_00");
    expect_at(s + 5, K_HA1,  LEAD0, "hex_addr1_00");
    expect_at(s + 6, K_STEP, 7'h00, "step_low_s6");
    expect_at(s + 7, K_STEP, 7'h01, "step_second");
    expect_at(s + 8, K_RD,   7'h01, "rd_addr_01");
    expect_at(s + 8, K_STEP, 7'h00, "step_low_s8");
    tick(11);

    // drop scan_en in a step cycle: manual load wins, no increment
    bus.scan_en  = 1'b0;
    bus.man_addr = 5'h05;
    expect_at(cyc,     K_RD,   7'h01, "rd_addr_before_toggle");
    expect_at(cyc,     K_STEP, 7'h00, "step_suppressed");
    expect_at(cyc + 1, K_RD,   7'h05, "toggle_loads_man");
    expect_at(cyc + 2, K_HA0,  SEG_5, "hex_addr0_5");
    expect_at(cyc + 2, K_HA1,  LEAD0, "hex_addr1_lead_of_05");
    tick(1);

    // reset mid-scan, then restart from 0 with a full period
    t = cyc;
    bus.scan_en = 1'b1;
    bus.wr_data = 4'hA;
    bus.rd_data = 4'h0;
    expect_at(t + 1, K_HW, SEG_A, "wdata_A");
    expect_at(t + 1, K_HR, SEG_0, "rdata_0");
    tick(2);
    reset_n = 1'b0;
    expect_at(cyc, K_RD,   7'h00, "midscan_reset_rd_addr");
    expect_at(cyc, K_STEP, 7'h00, "midscan_reset_step");
    expect_at(cyc, K_HA0,  BLANK, "midscan_reset_hex_addr0");
    expect_at(cyc, K_HA1,  BLANK, "midscan_reset_hex_addr1");
    expect_at(cyc, K_HW,   BLANK, "midscan_reset_hex_wdata");
    expect_at(cyc, K_HR,   BLANK, "midscan_reset_hex_rdata");
    tick(1);
    expect_at(cyc, K_HW, BLANK, "reset_held_hex_wdata");
    r = cyc;
    reset_n = 1'b1;
    expect_at(r + 1, K_HA0,  SEG_0, "post_reset_hex_addr0");
    expect_at(r + 1, K_STEP, 7'h00, "post_reset_step_r1");
    expect_at(r + 2, K_STEP, 7'h00, "post_reset_step_r2");
    expect_at(r + 3, K_STEP, 7'h01, "post_reset_first_step");
    expect_at(r + 3, K_RD,   7'h00, "post_reset_rd_addr_0");
    expect_at(r + 4, K_RD,   7'h01, "post_reset_rd_addr_1");
    tick(6);

    @(negedge clk);
    #1;
    foreach (exp_q[i]) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: expectation for cyc %0d left unchecked", exp_q[i].name, exp_q[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
